// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_fifo                                                  |
// | Purpose  : 8N1 UART receiver with show-ahead byte FIFO and activity LED. |
// |            Optional even-parity framing when UART_RX_PARITY_EN is set.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int LED_HOLD   = 2500000
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic                          rx_led
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_CW = $clog2(c_CLKS_PER_BIT);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam int c_LW = $clog2(LED_HOLD + 1);

  localparam logic [c_CW-1:0] c_HALF    = c_CW'(c_CLKS_PER_BIT / 2);
  localparam logic [c_CW-1:0] c_TERM    = c_CW'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
  localparam logic [c_PW-1:0] c_FULL    = c_PW'(FIFO_DEPTH);
  localparam logic [c_LW-1:0] c_LED_LD  = c_LW'(LED_HOLD);
  localparam logic [c_LW-1:0] c_LED_ONE = c_LW'(1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
  localparam logic [2:0] c_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd5;
`endif

  logic            r_sync1, r_rxs, r_rxs_d;
  logic [2:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_push_pend;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr, r_rd;
  logic            r_frame_err, r_overrun;
  logic [c_LW-1:0] r_led_cnt;

  logic w_tick, w_fall, w_stop_sample, w_par_ok, w_push_req, w_ferr_set;
  logic w_pop, w_push_ok, w_ovr_set;

  assign w_tick        = (r_cnt == c_TERM);
  assign w_fall        = r_rxs_d & ~r_rxs;
  assign w_stop_sample = (r_state == c_STOP) && w_tick;
  assign w_ferr_set    = w_stop_sample && !r_rxs;

`ifdef UART_RX_PARITY_EN
  logic r_par_bit, r_parity_err;
  assign w_par_ok   = ~(^r_shift ^ r_par_bit);
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
`endif

  assign w_push_req = w_stop_sample && r_rxs && w_par_ok;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  // r_shift holds the received byte until the push cycle; the next frame
  // cannot shift data in before then.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_push_pend <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit   <= 1'b0;
`endif
    end else begin
      r_push_pend <= w_push_req;
      r_cnt       <= w_tick ? '0 : r_cnt + c_CNT_ONE;
      case (r_state)
        c_IDLE: begin
          if (w_fall) begin
            r_state <= c_START;
            r_cnt   <= c_HALF;
          end
        end
        c_START: begin
          if (w_tick) begin
            r_state   <= r_rxs ? c_IDLE : c_DATA;
            r_bit_idx <= 3'd0;
          end
        end
        c_DATA: begin
          if (w_tick) begin
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= c_PARITY;
`else
              r_state <= c_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        c_PARITY: begin
          if (w_tick) begin
            r_par_bit <= r_rxs;
            r_state   <= c_STOP;
          end
        end
`endif
        c_STOP: begin
          if (w_tick) r_state <= r_rxs ? c_IDLE : c_BREAK;
        end
        c_BREAK: begin
          if (r_rxs) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
  assign w_pop     = rd_en && !rx_empty;
  assign w_push_ok = r_push_pend && (!rx_full || w_pop);
  assign w_ovr_set = r_push_pend && rx_full && !w_pop;

  always_ff @(posedge sys_clk_i) begin
    if (w_push_ok) r_mem[r_wr[c_AW-1:0]] <= r_shift;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_led_cnt    <= '0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_push_ok) r_wr <= r_wr + c_PTR_ONE;
      if (w_pop)     r_rd <= r_rd + c_PTR_ONE;
      r_frame_err  <= w_ferr_set | (r_frame_err & ~err_clr);
      r_overrun    <= w_ovr_set  | (r_overrun   & ~err_clr);
`ifdef UART_RX_PARITY_EN
      r_parity_err <= (w_stop_sample && !w_par_ok) | (r_parity_err & ~err_clr);
`endif
      if (w_push_ok)               r_led_cnt <= c_LED_LD;
      else if (r_led_cnt != '0)    r_led_cnt <= r_led_cnt - c_LED_ONE;
    end
  end

  assign rx_count  = r_wr - r_rd;
  assign rx_empty  = (r_wr == r_rd);
  assign rx_full   = (rx_count == c_FULL);
  assign rd_data   = rx_empty ? 8'h00 : r_mem[r_rd[c_AW-1:0]];
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_led    = (r_led_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_fifo                                               |
// | Purpose  : Directed self-checking bench for uart_rx_fifo (8N1 build).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;

  localparam int c_BIT = 10;
  localparam int c_LED = 300;

  logic       sys_clk_i = 1'b0;
  logic       sys_rst_i, uart_rx, rd_en, err_clr;
  logic [7:0] rd_data;
  logic       rx_empty, rx_full, frame_err, overrun, rx_led;
  logic [4:0] rx_count;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[6];

  uart_rx_fifo #(
    .CLK_FREQ(50000000), .BAUD(5000000), .FIFO_DEPTH(16), .LED_HOLD(c_LED)
  ) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .uart_rx(uart_rx),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_count(rx_count), .frame_err(frame_err), .overrun(overrun),
    .err_clr(err_clr), .rx_led(rx_led)
  );

  always #10 sys_clk_i = ~sys_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (c_BIT) @(negedge sys_clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (c_BIT) @(negedge sys_clk_i);
    end
    if (stop_ok) begin
      uart_rx = 1'b1;
      repeat (c_BIT) @(negedge sys_clk_i);
    end else begin
      uart_rx = 1'b0;
      repeat (30) @(negedge sys_clk_i);
      uart_rx = 1'b1;
      repeat (c_BIT) @(negedge sys_clk_i);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge sys_clk_i);
    rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge sys_clk_i);
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h6B, 1'b0, 1'b0, 1'b1};

    sys_rst_i = 1'b0; uart_rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    check("rst_empty", rx_empty, 1);
    check("rst_full", rx_full, 0);
    check("rst_count", rx_count, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_led", rx_led, 0);
    sys_rst_i = 1'b1;
    repeat (5) @(negedge sys_clk_i);

    // Single byte with latency measurement from the start edge
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int cyc;
        cyc = 0;
        while (rx_empty && cyc < 150) begin
          @(negedge sys_clk_i);
          cyc++;
        end
        lat = cyc;
      end
    join
    check("t1_latency_window", (lat >= 94 && lat <= 102), 1);
    check("t1_rd_data", rd_data, 8'hA5);
    check("t1_count", rx_count, 1);
    check("t1_led", rx_led, 1);
    pop();
    check("t1_empty_after_pop", rx_empty, 1);
    check("t1_count_after_pop", rx_count, 0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_ok);
      check($sformatf("vec%0d_empty", v), rx_empty, !vecs[v].exp_push);
      check($sformatf("vec%0d_ferr", v), frame_err, vecs[v].exp_ferr);
      if (vecs[v].exp_push) begin
        check($sformatf("vec%0d_data", v), rd_data, vecs[v].data);
        pop();
      end
      clear_errs();
      check($sformatf("vec%0d_ferr_clr", v), frame_err, 0);
    end

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    check("fill_full", rx_full, 1);
    check("fill_count", rx_count, 16);
    send_frame(8'h10, 1'b1);
    check("ovr_flag", overrun, 1);
    check("ovr_head", rd_data, 8'h00);
    check("ovr_count", rx_count, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), rd_data, 8'(i));
      pop();
    end
    check("drain_empty", rx_empty, 1);
    pop();
    check("pop_empty_count", rx_count, 0);
    check("ovr_sticky", overrun, 1);
    clear_errs();
    check("ovr_clr", overrun, 0);

    // Short glitch while idle
    uart_rx = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    uart_rx = 1'b1;
    repeat (30) @(negedge sys_clk_i);
    check("glitch_empty", rx_empty, 1);
    check("glitch_ferr", frame_err, 0);
    check("glitch_ovr", overrun, 0);
    send_frame(8'h5A, 1'b1);
    check("post_glitch_data", rd_data, 8'h5A);
    pop();

    // Pop coincident with the push into a full FIFO
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
    check("sim_full", rx_count, 16);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (98) @(negedge sys_clk_i);
        rd_en = 1'b1;
        @(negedge sys_clk_i);
        rd_en = 1'b0;
      end
    join
    check("sim_ovr", overrun, 0);
    check("sim_count", rx_count, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sim_drain_%0d", i), rd_data, (i < 15) ? 8'h21 + 8'(i) : 8'h77);
      pop();
    end

    // Reset in the middle of a frame with bytes queued
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    check("pre_rst_count", rx_count, 4);
    fork
      send_frame(8'hE7, 1'b1);
      begin
        repeat (40) @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        #1;
        check("mid_rst_empty", rx_empty, 1);
        check("mid_rst_count", rx_count, 0);
        check("mid_rst_data", rd_data, 8'h00);
        check("mid_rst_full", rx_full, 0);
        check("mid_rst_led", rx_led, 0);
      end
    join
    sys_rst_i = 1'b1;
    repeat (5) @(negedge sys_clk_i);
    send_frame(8'h81, 1'b1);
    check("post_rst_count", rx_count, 1);
    check("post_rst_data", rd_data, 8'h81);
    check("post_rst_led", rx_led, 1);
    pop();
    check("post_rst_empty", rx_empty, 1);

    repeat (c_LED + 20) @(negedge sys_clk_i);
    check("led_expired", rx_led, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
